// File: rtl/ex_mem_stage_buf.sv
// EX->MEM stage: two-entry skid buffer with lane-aligned byte enables and branch/jump PC select.
// Optional build macro EX_MEM_MISALIGN_TRAP_EN turns misaligned loads/stores into a flagged, request-free trap.
module ex_mem_stage_buf #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              cmp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   wdata_out,
  output logic [XLEN/8-1:0] mem_byte_enable_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              br_en_out,
  output logic [1:0]        pcmux_sel_out,
  output logic              misalign_out,
  output logic [1:0]        occupancy
);

  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   pc;
    logic              cmp;
  } entry_t;

  entry_t     head, tail, in_ent;
  logic [1:0] count;
  logic       push, pop;

  assign in_ent = '{opcode: opcode_in, funct3: funct3_in, ctrl: ctrl_in,
                    alu: alu_in, rs2: rs2_in, pc: pc_in, cmp: cmp_in};

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign occupancy = count;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the two entries are plain flops, so clearing them on reset is cheap and keeps data outputs at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_ent;
          else               tail <= in_ent;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Push with pop only happens at count 1: the new entry replaces the head.
        2'b11:   head <= in_ent;
        default: ;
      endcase
    end
  end

  assign ctrl_out = head.ctrl;
  assign alu_out  = head.alu;
  assign pc_out   = head.pc;

  logic              unused_funct3_msb;
  assign unused_funct3_msb = head.funct3[2];

  logic [OFFW-1:0]  offset, size_m1, off_used;
  logic [LANES-1:0] base_mask, lane_mask;
  logic             size_ok, is_load, is_store;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    base_mask = '0;
    size_m1   = '0;
    unique case (head.funct3[1:0])
      2'b00: begin base_mask = LANES'(8'h01); size_m1 = OFFW'(0); end
      2'b01: begin base_mask = LANES'(8'h03); size_m1 = OFFW'(1); end
      2'b10: begin base_mask = LANES'(8'h0F); size_m1 = OFFW'(3); end
      default: begin base_mask = LANES'(8'hFF); size_m1 = OFFW'(7); end
    endcase
  end

  assign offset    = head.alu[OFFW-1:0];
  assign off_used  = offset & ~size_m1;
  assign lane_mask = base_mask << off_used;
  assign wdata_out = head.rs2 << {off_used, 3'b000};
  // 8-byte accesses only exist on a 64-bit datapath.
  assign size_ok   = (LANES == 8) || (head.funct3[1:0] != 2'b11);
  assign is_load   = (head.opcode == OP_LOAD);
  assign is_store  = (head.opcode == OP_STORE);

`ifdef EX_MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((offset & size_m1) != '0);
`endif

  always_comb begin
    mem_byte_enable_out = '0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    misalign_out        = 1'b0;
    br_en_out           = 1'b0;
    pcmux_sel_out       = 2'b00;
    if (out_valid) begin
      if (is_load || is_store) begin
        if (size_ok) begin
`ifdef EX_MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            misalign_out = 1'b1;
          end else begin
            mem_byte_enable_out = lane_mask;
            mem_read_out        = is_load;
            mem_write_out       = is_store;
          end
`else
          mem_byte_enable_out = lane_mask;
          mem_read_out        = is_load;
          mem_write_out       = is_store;
`endif
        end
      end else begin
        mem_byte_enable_out = '1;
      end
      unique case (head.opcode)
        OP_BRANCH: begin
          br_en_out     = head.cmp;
          pcmux_sel_out = head.cmp ? 2'b01 : 2'b00;
        end
        OP_JAL: begin
          br_en_out     = 1'b1;
          pcmux_sel_out = 2'b01;
        end
        OP_JALR: begin
          br_en_out     = 1'b1;
          pcmux_sel_out = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
